spawn_scheduler: RTL and testbench

//  Timing and lane scheduler for obstacle spawning. It serves the obstacle generator's

---
 rtl/spawn_scheduler.sv | 121 ++++++++++++
 tb/tb_spawn_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
// Obstacle spawn scheduler: waits a requested number of video frames, then grants
// a lane that has not spawned within the last LANE_GAP frames.
module spawn_scheduler #(
    parameter int LANE_GAP   = 8,
    parameter int WAIT_SHIFT = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       game_reset,
    input  logic       frame_trigger,
    input  logic       start_timer,
    input  logic [5:0] time_to_wait,
    input  logic [1:0] random_lane,
    output logic       expired_out,
    output logic [1:0] lane_out,
    output logic       busy
);

    localparam int CW = 6 + WAIT_SHIFT;

    typedef enum logic [1:0] {IDLE, COUNT, PICK} state_t;

    state_t          state_q;
    logic [CW-1:0]   wait_cnt_q;
    logic [2:0][5:0] cool_q;

    logic [CW-1:0] wait_load;
    logic [1:0]    first_lane;
    logic [1:0]    cand1;
    logic [1:0]    cand2;
    logic [1:0]    win;
    logic          found;

    function automatic logic [1:0] next_lane(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    assign wait_load = CW'(time_to_wait) << WAIT_SHIFT;

    // Rotating priority starting at the sanitised random lane.
    always_comb begin
        first_lane = (random_lane == 2'd3) ? 2'd0 : random_lane;
        cand1      = next_lane(first_lane);
        cand2      = next_lane(cand1);
        found      = 1'b1;
        win        = first_lane;
        if (cool_q[first_lane] == 6'd0) begin
            win = first_lane;
        end else if (cool_q[cand1] == 6'd0) begin
            win = cand1;
        end else if (cool_q[cand2] == 6'd0) begin
            win = cand2;
        end else begin
            found = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            // NOTE: the cooldowns are a small register array, not RAM, so they take the reset.
            cool_q      <= '0;
            expired_out <= 1'b0;
            lane_out    <= 2'd0;
            busy        <= 1'b0;
        end else if (game_reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            cool_q      <= '0;
            expired_out <= 1'b0;
            lane_out    <= 2'd0;
            busy        <= 1'b0;
        end else begin
            expired_out <= 1'b0;

            if (frame_trigger) begin
                for (int i = 0; i < 3; i++) begin
                    if (cool_q[i] != 6'd0) begin
                        cool_q[i] <= cool_q[i] - 6'd1;
                    end
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (start_timer) begin
                        wait_cnt_q <= wait_load;
                        busy       <= 1'b1;
                        state_q    <= (wait_load == '0) ? PICK : COUNT;
                    end
                end
                COUNT: begin
                    if (frame_trigger) begin
                        if (wait_cnt_q <= CW'(1)) begin
                            wait_cnt_q <= '0;
                            state_q    <= PICK;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - CW'(1);
                        end
                    end
                end
                PICK: begin
                    if (found) begin
                        expired_out <= 1'b1;
                        lane_out    <= win;
                        // NOTE: this later non-blocking write overrides the frame decrement above.
                        cool_q[win] <= 6'(LANE_GAP);
                        busy        <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler: stimulus pushes expected (lane, cycle) pulses,
// negedge monitors pop and compare whenever expired_out is seen.
module tb_spawn_scheduler;

    typedef struct {
        int lane;
        int cycle;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_in = 1'b1;
    logic       game_reset = 1'b0;
    logic       frame_trigger = 1'b0;
    logic       start_timer = 1'b0;
    logic       start2 = 1'b0;
    logic [5:0] ttw = 6'd0;
    logic [5:0] ttw2 = 6'd0;
    logic [1:0] random_lane = 2'd0;

    logic       expired_out, busy, expired2, busy2;
    logic [1:0] lane_out, lane2;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    spawn_scheduler #(.LANE_GAP(8), .WAIT_SHIFT(0)) dut (
        .clk_in(clk), .rst_in(rst_in), .game_reset(game_reset),
        .frame_trigger(frame_trigger), .start_timer(start_timer),
        .time_to_wait(ttw), .random_lane(random_lane),
        .expired_out(expired_out), .lane_out(lane_out), .busy(busy)
    );

    spawn_scheduler #(.LANE_GAP(8), .WAIT_SHIFT(2)) dut_s2 (
        .clk_in(clk), .rst_in(rst_in), .game_reset(game_reset),
        .frame_trigger(frame_trigger), .start_timer(start2),
        .time_to_wait(ttw2), .random_lane(random_lane),
        .expired_out(expired2), .lane_out(lane2), .busy(busy2)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (expired_out === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut_pulse_cycle", cyc, e1.cycle);
                check("dut_pulse_lane", 32'(lane_out), e1.lane);
            end
        end
    end

    always @(negedge clk) begin
        if (expired2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("s2_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e2 = q2.pop_front();
                check("s2_pulse_cycle", cyc, e2.cycle);
                check("s2_pulse_lane", 32'(lane2), e2.lane);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic frame();
        frame_trigger = 1'b1;
        step();
        frame_trigger = 1'b0;
    endtask

    task automatic frames(input int count, input int gap);
        repeat (count) begin
            idle(gap - 1);
            frame();
        end
    endtask

    task automatic pulse_game_reset();
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
    endtask

    task automatic issue(input logic [5:0] n, input logic [1:0] h);
        start_timer = 1'b1;
        ttw         = n;
        random_lane = h;
        step();
        start_timer = 1'b0;
    endtask

    task automatic issue2(input logic [5:0] n, input logic [1:0] h);
        start2      = 1'b1;
        ttw2        = n;
        random_lane = h;
        step();
        start2      = 1'b0;
    endtask

    // The pulse is expected on the edge after the current one.
    task automatic expect1(input int lane);
        exp_t e;
        e.lane  = lane;
        e.cycle = cyc + 1;
        q1.push_back(e);
    endtask

    task automatic expect2(input int lane);
        exp_t e;
        e.lane  = lane;
        e.cycle = cyc + 1;
        q2.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        idle(3);
        check("rst_expired", expired_out, 1'b0);
        check("rst_lane", lane_out, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_busy_s2", busy2, 1'b0);
        rst_in = 1'b0;
        step();

        // Asynchronous reset with the clock stopped
        issue(6'd5, 2'd1);
        check("busy_after_start", busy, 1'b1);
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst_in = 1'b1;
        #2;
        check("async_busy", busy, 1'b0);
        check("async_expired", expired_out, 1'b0);
        check("async_lane", lane_out, 2'd0);
        rst_in = 1'b0;
        #3 clk_en = 1'b1;
        step();

        // Wait of 3 frames, lane 1 requested
        pulse_game_reset();
        issue(6'd3, 2'd1);
        frames(3, 10);
        check("busy_in_pick", busy, 1'b1);
        expect1(1);
        step();
        check("busy_falls", busy, 1'b0);
        idle(2);
        check("lane_held", lane_out, 2'd1);

        // Random lane 3 maps to lane 0; back-to-back request in the pulse cycle skips cooling lane 0
        pulse_game_reset();
        issue(6'd0, 2'd3);
        expect1(0);
        step();
        issue(6'd0, 2'd0);
        expect1(1);
        idle(3);

        // All lanes cooling: stuck in PICK until lane 0 frees first
        pulse_game_reset();
        issue(6'd0, 2'd0);
        expect1(0);
        step();
        frame();
        issue(6'd0, 2'd0);
        expect1(1);
        step();
        frame();
        issue(6'd0, 2'd0);
        expect1(2);
        step();
        issue(6'd0, 2'd2);
        frames(5, 10);
        check("busy_all_cooling", busy, 1'b1);
        frames(1, 10);
        expect1(0);
        idle(3);

        // game_reset mid-COUNT; start_timer held while busy is ignored
        pulse_game_reset();
        issue(6'd0, 2'd2);
        expect1(2);
        step();
        issue(6'd3, 2'd1);
        start_timer = 1'b1;
        ttw         = 6'd0;
        idle(20);
        start_timer = 1'b0;
        check("busy_ignore_start", busy, 1'b1);
        frames(1, 10);
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        check("greset_busy", busy, 1'b0);
        check("greset_lane", lane_out, 2'd0);
        frames(4, 10);
        check("greset_busy_later", busy, 1'b0);

        // WAIT_SHIFT=2: 1 -> 4 frames, 63 -> 252 frames
        pulse_game_reset();
        issue2(6'd1, 2'd1);
        frames(3, 3);
        check("s2_busy_after_3", busy2, 1'b1);
        frames(1, 3);
        expect2(1);
        step();
        check("s2_busy_falls", busy2, 1'b0);
        issue2(6'd63, 2'd1);
        frames(251, 3);
        check("s2_busy_after_251", busy2, 1'b1);
        frames(1, 3);
        expect2(1);
        idle(4);

        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
